// File: rtl/dmac_read_responder.sv
// AXI4 read-channel responder. It turns AR bursts into 1-cycle-latency memory reads and returns the data through a 4-entry R FIFO.
// Optional burst error checking is enabled by defining DMAC_RD_RESP_ERR_CHECK_EN.
module dmac_read_responder #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  input  logic [ADDR_WD-1:0] s_axi_araddr,
  input  logic [7:0]         s_axi_arlen,
  input  logic [2:0]         s_axi_arsize,
  input  logic [1:0]         s_axi_arburst,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [DATA_WD-1:0] s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rlast,
  output logic               mem_rd_en,
  output logic [ADDR_WD-1:0] mem_rd_addr,
  input  logic [DATA_WD-1:0] mem_rd_data
);
  localparam int unsigned STRB_WD = DATA_WD / 8;
  localparam logic [ADDR_WD-1:0] ALIGN_MSK = ~ADDR_WD'(STRB_WD - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t r_state, w_state_nxt;

  logic               r_arrdy_en;
  logic [ADDR_WD-1:0] r_addr, r_inc, r_mask;
  logic [1:0]         r_burst;
  logic               r_err;
  logic [7:0]         r_beats_left;
  logic               r_p1_vld, r_p1_last, r_p1_err;
  logic [DATA_WD-1:0] r_fifo_data [4];
  logic               r_fifo_last [4];
  logic               r_fifo_err  [4];
  logic [1:0]         r_wptr, r_rptr;
  logic [2:0]         r_count;

  logic               w_ar_hs, w_credit, w_issue, w_last_beat, w_pop, w_ar_err;
  logic [1:0]         w_ar_burst;
  logic [ADDR_WD-1:0] w_inc, w_mask, w_addr_nxt;

  assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
  assign w_inc       = ADDR_WD'(1) << s_axi_arsize;
  assign w_mask      = ((ADDR_WD'(s_axi_arlen) + ADDR_WD'(1)) << s_axi_arsize) - ADDR_WD'(1);
  // A beat issued now sits in r_p1 next cycle, so FIFO plus one pipeline stage bounds occupancy at 4
  assign w_credit    = (r_count + {2'b00, r_p1_vld}) < 3'd4;
  assign w_issue     = (r_state == S_BURST) && w_credit;
  assign w_last_beat = (r_beats_left == 8'd0);
  assign w_pop       = s_axi_rvalid && s_axi_rready;

`ifdef DMAC_RD_RESP_ERR_CHECK_EN
  localparam int unsigned LG_STRB = $clog2(STRB_WD);
  logic w_wrap_len_ok;
  always_comb begin
    w_wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                    (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    w_ar_err      = (s_axi_arburst == 2'b11) || (32'(s_axi_arsize) > LG_STRB) ||
                    ((s_axi_arburst == 2'b10) &&
                     (!w_wrap_len_ok || ((s_axi_araddr & (w_inc - ADDR_WD'(1))) != '0)));
  end
  assign w_ar_burst = s_axi_arburst;
`else
  assign w_ar_err   = 1'b0;
  assign w_ar_burst = (s_axi_arburst == 2'b11) ? 2'b01 : s_axi_arburst;
`endif

  always_comb begin
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = (r_addr & ~r_mask) | ((r_addr + r_inc) & r_mask);
      default: w_addr_nxt = r_addr + r_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ar_hs) w_state_nxt = S_BURST;
      S_BURST: if (w_issue && w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state == S_IDLE) && r_arrdy_en;
    mem_rd_en     = w_issue && !r_err;
    mem_rd_addr   = mem_rd_en ? (r_addr & ALIGN_MSK) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arrdy_en   <= 1'b0;
      r_addr       <= '0;
      r_inc        <= '0;
      r_mask       <= '0;
      r_burst      <= '0;
      r_err        <= 1'b0;
      r_beats_left <= '0;
      r_p1_vld     <= 1'b0;
      r_p1_last    <= 1'b0;
      r_p1_err     <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_arrdy_en <= 1'b1;
      if (w_ar_hs) begin
        r_addr       <= s_axi_araddr;
        r_inc        <= w_inc;
        r_mask       <= w_mask;
        r_burst      <= w_ar_burst;
        r_err        <= w_ar_err;
        r_beats_left <= s_axi_arlen;
      end else if (w_issue) begin
        r_addr       <= w_addr_nxt;
        r_beats_left <= r_beats_left - 8'd1;
      end
      r_p1_vld  <= w_issue;
      r_p1_last <= w_last_beat;
      r_p1_err  <= r_err;
      if (r_p1_vld) r_wptr <= r_wptr + 2'd1;
      if (w_pop)    r_rptr <= r_rptr + 2'd1;
      case ({r_p1_vld, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count alone decide what is visible
  always_ff @(posedge clk) begin
    if (r_p1_vld) begin
      r_fifo_data[r_wptr] <= r_p1_err ? '0 : mem_rd_data;
      r_fifo_last[r_wptr] <= r_p1_last;
      r_fifo_err[r_wptr]  <= r_p1_err;
    end
  end

  always_comb begin
    s_axi_rvalid = (r_count != 3'd0);
    s_axi_rdata  = s_axi_rvalid ? r_fifo_data[r_rptr] : '0;
    s_axi_rresp  = (s_axi_rvalid && r_fifo_err[r_rptr]) ? 2'b10 : 2'b00;
    s_axi_rlast  = s_axi_rvalid && r_fifo_last[r_rptr];
  end
endmodule

// File: tb/tb_dmac_read_responder.sv
// Randomized bench for dmac_read_responder. A queue-based burst model predicts the memory reads and R beats, and a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dmac_read_responder;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned rr_mode = 0;
  int          outstanding = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;
  logic [AW-1:0] exp_addr_q[$];
  beat_t         exp_beat_q[$];

  always #5 clk = ~clk;

  dmac_read_responder #(.ADDR_WD(AW), .DATA_WD(DW)) u_dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // The address of beat i is computed directly from the burst geometry, not stepped beat by beat
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a0, input int unsigned len,
                                              input int unsigned sz, input logic [1:0] bt,
                                              input int unsigned i);
    longint unsigned inc, ws, lo, a, r;
    inc = longint'(1) << sz;
    a   = longint'(a0);
    if (bt == 2'd0) r = a;
    else if (bt == 2'd2) begin
      ws = longint'(len + 1) * inc;
      lo = (a / ws) * ws;
      r  = lo + ((a - lo + longint'(i) * inc) % ws);
    end else r = a + longint'(i) * inc;
    return AW'(r) & ~32'h3;
  endfunction

  task automatic model_ar(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt);
    logic  err;
    beat_t b;
    logic [AW-1:0] ba;
    err = 1'b0;
`ifdef DMAC_RD_RESP_ERR_CHECK_EN
    err = (bt == 2'd3) || (sz > 3'd2) ||
          ((bt == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
          ((bt == 2'd2) && ((a % (32'd1 << sz)) != 0));
`endif
    for (int unsigned i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, len, sz, bt, i);
      if (!err) exp_addr_q.push_back(ba);
      b.data = err ? '0 : memf(ba);
      b.resp = err ? 2'd2 : 2'd0;
      b.last = (i == int'(len));
      exp_beat_q.push_back(b);
    end
  endtask

  // Memory: data for a read seen in cycle n is presented during cycle n+1
  logic          pend = 1'b0;
  logic [AW-1:0] paddr = '0;
  initial begin
    forever begin
      @(negedge clk);
      pend  = mem_rd_en;
      paddr = mem_rd_addr;
      @(posedge clk);
      #1;
      mem_rd_data = pend ? memf(paddr) : DW'($urandom);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rready = (rr_mode == 0) ? 1'b1 : (rr_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_resp;
  logic          prev_last;
  beat_t         mb;
  always @(negedge clk) begin
    if (!rst) prev_stall = 1'b0;
    else begin
      if (arvalid && arready) model_ar(araddr, arlen, arsize, arburst);
      if (mem_rd_en) begin
        outstanding++;
        if (exp_addr_q.size() == 0) chk("rd_unexpected", 64'(mem_rd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q.pop_front()));
        chk("credit_le4", 64'(outstanding <= 4), 64'd1);
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(rvalid), 64'd1);
        chk("hold_data", 64'(rdata), 64'(prev_data));
        chk("hold_resp", 64'(rresp), 64'(prev_resp));
        chk("hold_last", 64'(rlast), 64'(prev_last));
      end
      if (rvalid && rready) begin
        if (exp_beat_q.size() == 0) chk("r_unexpected", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mb = exp_beat_q.pop_front();
          chk("r_data", 64'(rdata), 64'(mb.data));
          chk("r_resp", 64'(rresp), 64'(mb.resp));
          chk("r_last", 64'(rlast), 64'(mb.last));
          if (mb.resp == 2'd0) outstanding--;
        end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_resp  = rresp;
      prev_last  = rlast;
    end
  end

  task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt);
    int unsigned t = 0;
    @(posedge clk);
    #1;
    arvalid = 1'b1; araddr = a; arlen = len; arsize = sz; arburst = bt;
    do begin
      @(negedge clk);
      t++;
    end while (!arready && t < 300);
    if (!arready) chk("ar_timeout", 64'(arready), 64'd1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((exp_beat_q.size() != 0 || rvalid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 64'(exp_beat_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Cycle-exact check: cycle 0 is the AR handshake and the FIFO must be empty on entry
  task automatic run_directed(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                              input logic [1:0] bt, input logic err,
                              input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                              input logic [AW-1:0] e2, input logic [AW-1:0] e3);
    int unsigned n;
    logic [AW-1:0] ea [4];
    ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
    n = int'(len) + 1;
    send_ar(a, len, sz, bt);
    for (int unsigned k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      chk("d_mem_en", 64'(mem_rd_en), 64'(!err && k <= n));
      if (!err && k <= n) chk("d_mem_addr", 64'(mem_rd_addr), 64'(ea[k-1]));
      chk("d_arready", 64'(arready), 64'(k > n));
      chk("d_rvalid", 64'(rvalid), 64'(k >= 3 && k <= n + 2));
      if (rvalid) begin
        chk("d_rlast", 64'(rlast), 64'(k == n + 2));
        chk("d_rresp", 64'(rresp), err ? 64'd2 : 64'd0);
        if (err) chk("d_rdata", 64'(rdata), 64'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned issued;
    logic [AW-1:0] a;
    logic [7:0]    ln;
    logic [2:0]    sz;
    logic [1:0]    bt;

    chk("pin_wrap", 64'(beat_addr(32'h108, 3, 2, 2'd2, 2)), 64'h100);
    chk("pin_incr_wrap32", 64'(beat_addr(32'hFFFF_FFFC, 1, 2, 2'd1, 1)), 64'h0);
    chk("pin_fixed", 64'(beat_addr(32'h43, 2, 0, 2'd0, 2)), 64'h40);

    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mem_en", 64'(mem_rd_en), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b1;
    #1 chk("rel_arready_pre", 64'(arready), 64'd0);
    @(negedge clk);
    chk("rel_arready_post", 64'(arready), 64'd1);

    rr_mode = 0;
    repeat (2) @(negedge clk);
    run_directed(32'h100, 8'd3, 3'd2, 2'd1, 1'b0, 32'h100, 32'h104, 32'h108, 32'h10C);
    run_directed(32'h108, 8'd3, 3'd2, 2'd2, 1'b0, 32'h108, 32'h10C, 32'h100, 32'h104);
    run_directed(32'h40,  8'd2, 3'd2, 2'd0, 1'b0, 32'h40, 32'h40, 32'h40, 32'h0);
    run_directed(32'h13,  8'd0, 3'd0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0);
`ifdef DMAC_RD_RESP_ERR_CHECK_EN
    run_directed(32'h80,  8'd1, 3'd2, 2'd3, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    run_directed(32'h84,  8'd1, 3'd2, 2'd1, 1'b0, 32'h84, 32'h88, 32'h0, 32'h0);
`endif
    drain();

    // rready held low for cycles 4..13 of a 16-beat burst
    send_ar(32'h200, 8'd15, 3'd2, 2'd1);
    issued = 0;
    for (int unsigned k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (mem_rd_en) issued++;
      if (k == 3) rr_mode = 2;
    end
    rr_mode = 0;
    chk("stall_issued", 64'(issued), 64'd5);
    drain();

    rr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      bt = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 2));
      ln = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 15));
      a  = AW'($urandom);
      if (bt == 2'd2) begin
        case ($urandom_range(0, 3))
          0: ln = 8'd1;
          1: ln = 8'd3;
          2: ln = 8'd7;
          default: ln = 8'd15;
        endcase
        a = a & ~((32'd1 << sz) - 32'd1);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_ar(a, ln, sz, bt);
    end
    drain();
    rr_mode = 0;

    // asynchronous reset in cycle 5 of an 8-beat INCR burst
    send_ar(32'h300, 8'd7, 3'd2, 2'd1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_arready", 64'(arready), 64'd0);
    chk("mid_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rdata", 64'(rdata), 64'd0);
    chk("mid_rresp", 64'(rresp), 64'd0);
    chk("mid_rlast", 64'(rlast), 64'd0);
    chk("mid_mem_en", 64'(mem_rd_en), 64'd0);
    chk("mid_mem_addr", 64'(mem_rd_addr), 64'd0);
    exp_addr_q.delete();
    exp_beat_q.delete();
    outstanding = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rel_arready_pre", 64'(arready), 64'd0);
    @(negedge clk);
    chk("mid_rel_arready", 64'(arready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_stale_r", 64'(rvalid), 64'd0);
      chk("mid_no_stale_rd", 64'(mem_rd_en), 64'd0);
    end
    run_directed(32'h100, 8'd3, 3'd2, 2'd1, 1'b0, 32'h100, 32'h104, 32'h108, 32'h10C);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
